// File: rtl/prog_delay_pkg.sv
// Shared types and helpers for the clocked programmable delay.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package prog_delay_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2
    } state_e;

    // Bits needed to index a buffer of the given depth (never less than 1).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // (a - b) mod depth for a in [0, depth-1] and b in [0, depth-1].
    // Works for any depth, not only powers of two.
    function automatic int mod_sub(input int a, input int b, input int depth);
        int r;
        r = a - b;
        if (r < 0) begin
            r = r + depth;
        end
        return r;
    endfunction

endpackage

// File: rtl/prog_delay_chan.sv
// One channel: circular history store, read-index selection and output register.
// Latency: NOMINAL_DELAY + code cycles from sample to out_dat (1 cycle when bypassed).
// Backpressure: none; a sample is stored every cycle and the output is blanked to 0 unless enabled.
module prog_delay_chan
    import prog_delay_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int CODE_W        = 3,
    parameter int NOMINAL_DELAY = 2,
    parameter int DEPTH         = 9,
    parameter int PTR_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_dat,
    input  logic [CODE_W-1:0] code,
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic              dly_vld,
    input  logic              byp,
    output logic [WIDTH-1:0]  out_dat
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    // History store: one slot per cycle, written in every state, never reset.
    always_ff @(posedge clk) begin
        mem_q[wr_ptr] <= in_dat;
    end

    // The slot written at the upcoming edge is wr_ptr, so the sample taken
    // D cycles before the output edge sits D-1 slots behind it.
    always_comb begin
        rd_ptr = PTR_W'(mod_sub(int'(wr_ptr), NOMINAL_DELAY - 1 + int'(code), DEPTH));
    end

    // Output select: live input when bypassed, delayed sample when valid, else zero.
    always_comb begin
        out_d = '0;
        if (byp) begin
            out_d = in_dat;
        end else if (dly_vld) begin
            out_d = mem_q[rd_ptr];
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_dat = out_q;

endmodule

// File: rtl/prog_delay_sync.sv
// Multi-channel clocked programmable delay over a shared write pointer; optional PROG_DELAY_BYPASS_EN adds a bypass input.
// Latency: NOMINAL_DELAY + code_c cycles per channel; output blanked for the settle window after reset or a code load.
// Backpressure: code_ready is high only in RUN; code_valid while not ready is ignored (sender holds).
module prog_delay_sync
    import prog_delay_pkg::*;
#(
    parameter int CH            = 2,
    parameter int WIDTH         = 8,
    parameter int CODE_W        = 3,
    parameter int NOMINAL_DELAY = 2,
    parameter int DEFAULT_CODE  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH*WIDTH-1:0] in_data,
    input  logic [CH*CODE_W-1:0] code,
    input  logic                code_valid,
    output logic                code_ready,
`ifdef PROG_DELAY_BYPASS_EN
    input  logic                bypass,
`endif
    output logic [CH*WIDTH-1:0] out_data,
    output logic                out_valid
);

    localparam int DEPTH = NOMINAL_DELAY + (1 << CODE_W) - 1;
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CODE_W-1:0] DEF_C   = CODE_W'(DEFAULT_CODE);
    localparam logic [CNT_W-1:0]  RST_CNT = CNT_W'(NOMINAL_DELAY + DEFAULT_CODE);
    localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(DEPTH - 1);

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [CH-1:0][CODE_W-1:0]   code_q, code_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic                        code_ready_q, code_ready_d;
    logic                        out_valid_q, out_valid_d;
    logic [CODE_W-1:0]           max_code;
    logic [CNT_W-1:0]            settle_new;
    logic                        accept;
    logic                        dly_vld;
    logic                        byp;

`ifdef PROG_DELAY_BYPASS_EN
    assign byp = bypass;
`else
    assign byp = 1'b0;
`endif

    // Largest incoming code sets the shared settle window for a new load.
    always_comb begin
        max_code = '0;
        for (int c = 0; c < CH; c++) begin
            if (code[c*CODE_W +: CODE_W] > max_code) begin
                max_code = code[c*CODE_W +: CODE_W];
            end
        end
        settle_new = CNT_W'(NOMINAL_DELAY) + CNT_W'(max_code);
    end

    // Next state: pointer advance, settle countdown, code acceptance.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
        accept   = code_valid && code_ready_q;
        case (state_q)
            RUN: begin
                if (accept) begin
                    state_d = SETTLE;
                    cnt_d   = settle_new;
                    code_d  = code;
                end
            end
            default: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
        endcase
        dly_vld      = (state_d == RUN);
        code_ready_d = dly_vld;
        out_valid_d  = dly_vld || byp;
    end

    // FSM, counter, active codes, write pointer and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            cnt_q        <= RST_CNT;
            code_q       <= {CH{DEF_C}};
            wr_ptr_q     <= '0;
            code_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            wr_ptr_q     <= wr_ptr_d;
            code_ready_q <= code_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_chan
        prog_delay_chan #(
            .WIDTH         (WIDTH),
            .CODE_W        (CODE_W),
            .NOMINAL_DELAY (NOMINAL_DELAY),
            .DEPTH         (DEPTH),
            .PTR_W         (PTR_W)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_dat  (in_data[c*WIDTH +: WIDTH]),
            .code    (code_q[c]),
            .wr_ptr  (wr_ptr_q),
            .dly_vld (dly_vld),
            .byp     (byp),
            .out_dat (out_data[c*WIDTH +: WIDTH])
        );
    end

    assign code_ready = code_ready_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_prog_delay_sync.sv
// Scoreboard bench for prog_delay_sync: randomized samples and code loads against a sample-history model.
// Latency: expected output for every clock edge is queued when the stimulus for that edge is issued.
// Backpressure: a code is held until the model says it is accepted.
module tb_prog_delay_sync;

    localparam int CH       = 2;
    localparam int WIDTH    = 8;
    localparam int CODE_W   = 3;
    localparam int NOM      = 2;
    localparam int DEF_CODE = 0;
    localparam int DW       = CH * WIDTH;
    localparam int CW       = CH * CODE_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic [CW-1:0] code;
    logic          code_valid;
    logic          code_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
`ifdef PROG_DELAY_BYPASS_EN
    logic          bypass;
`endif

    prog_delay_sync #(
        .CH            (CH),
        .WIDTH         (WIDTH),
        .CODE_W        (CODE_W),
        .NOMINAL_DELAY (NOM),
        .DEFAULT_CODE  (DEF_CODE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
`ifdef PROG_DELAY_BYPASS_EN
        .bypass     (bypass),
`endif
        .out_data   (out_data),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            n;
        logic          vld;
        logic          rdy;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] hist [int];   // hist[e]: sample presented after edge e
    int            edge_n = 0;
    int            tests  = 0;
    int            fails  = 0;

    // Reference model: active codes, edge at which output becomes valid, RUN flag.
    int  m_code [CH];
    int  m_valid_from;
    bit  m_ready;
    bit  last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_n, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'($urandom);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) m_code[c] = DEF_CODE;
        m_ready      = 1'b0;
        m_valid_from = edge_n + NOM + DEF_CODE;
    endtask

    // Drive one cycle of stimulus and queue what the outputs must show after the next edge.
    task automatic cycle(input logic [DW-1:0] d, input bit cv, input logic [CW-1:0] cd, input bit byp);
        exp_t          x;
        logic [DW-1:0] h;
        int            n;
        int            mx;
        int            dly;
        in_data    = d;
        code_valid = cv;
        code       = cd;
`ifdef PROG_DELAY_BYPASS_EN
        bypass     = byp;
`endif
        hist[edge_n] = d;
        n        = edge_n + 1;
        last_acc = cv && m_ready;
        if (last_acc) begin
            mx = 0;
            for (int c = 0; c < CH; c++) begin
                m_code[c] = int'(cd[c*CODE_W +: CODE_W]);
                if (m_code[c] > mx) mx = m_code[c];
            end
            m_valid_from = n + NOM + mx;
        end
        m_ready = (n >= m_valid_from);
        x.n   = n;
        x.rdy = m_ready;
        x.vld = m_ready;
        x.dat = '0;
        if (byp) begin
            x.vld = 1'b1;
            x.dat = d;
        end else if (m_ready) begin
            for (int c = 0; c < CH; c++) begin
                dly = NOM + m_code[c];
                h   = hist[n - dly];
                x.dat[c*WIDTH +: WIDTH] = h[c*WIDTH +: WIDTH];
            end
        end
        exp_q.push_back(x);
        tick();
    endtask

    // Offer a code and hold it until accepted (bounded).
    task automatic load_code(input logic [CW-1:0] cd);
        int k;
        k = 0;
        do begin
            cycle(rnd(), 1'b1, cd, 1'b0);
            k++;
        end while (!last_acc && k < 64);
    endtask

    // Assert reset mid-cycle, check outputs clear at once, hold, then release.
    task automatic apply_reset(input int ncyc);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_code_ready", 32'(code_ready), 32'd0);
        code_valid = 1'b0;
`ifdef PROG_DELAY_BYPASS_EN
        bypass = 1'b0;
`endif
        repeat (ncyc) tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: compare DUT outputs against the queued expectation for each edge.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].n <= edge_n) begin
                x = exp_q.pop_front();
                chk("out_valid", 32'(out_valid), 32'(x.vld));
                chk("code_ready", 32'(code_ready), 32'(x.rdy));
                chk("out_data", 32'(out_data), 32'(x.dat));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

    initial begin : stim
        bit rb;
        rst_n      = 1'b1;
        in_data    = '0;
        code       = '0;
        code_valid = 1'b0;
`ifdef PROG_DELAY_BYPASS_EN
        bypass     = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_out_data", 32'(out_data), 32'd0);
        chk("init_code_ready", 32'(code_ready), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        model_reset();

        // Ramp after reset: default delay of NOM on both channels.
        for (int i = 0; i < 12; i++) begin
            cycle({8'(8'h80 + i), 8'(i)}, 1'b0, '0, 1'b0);
        end

        // Load {ch1=5, ch0=3}: accepted immediately, 7-cycle blanking.
        cycle(rnd(), 1'b1, {3'd5, 3'd3}, 1'b0);
        repeat (20) cycle(rnd(), 1'b0, '0, 1'b0);

        // Maximum delay across many pointer wraps.
        load_code({3'd7, 3'd7});
        repeat (200) cycle(rnd(), 1'b0, '0, 1'b0);

        // Code held through SETTLE: one accept on the first RUN cycle.
        load_code({3'd3, 3'd0});
        load_code({3'd1, 3'd2});
        repeat (12) cycle(rnd(), 1'b0, '0, 1'b0);

        // Reset three cycles into SETTLE restores the default code.
        load_code({3'd5, 3'd3});
        repeat (3) cycle(rnd(), 1'b0, '0, 1'b0);
        apply_reset(2);
        repeat (15) cycle(rnd(), 1'b0, '0, 1'b0);

`ifdef PROG_DELAY_BYPASS_EN
        // Bypass during SETTLE, release before RUN, then a short bypass in RUN.
        load_code({3'd4, 3'd4});
        repeat (4) cycle(rnd(), 1'b0, '0, 1'b1);
        repeat (10) cycle(rnd(), 1'b0, '0, 1'b0);
        repeat (3) cycle(rnd(), 1'b0, '0, 1'b1);
        repeat (6) cycle(rnd(), 1'b0, '0, 1'b0);
`endif

        // Random loads and samples.
        for (int i = 0; i < 250; i++) begin
`ifdef PROG_DELAY_BYPASS_EN
            rb = ($urandom_range(0, 9) == 0);
`else
            rb = 1'b0;
`endif
            cycle(rnd(), ($urandom_range(0, 7) == 0), CW'($urandom), rb);
        end

        // Reset while RUN with live data must clear outputs at once.
        for (int k = 0; k < 20 && !m_ready; k++) begin
            cycle(rnd(), 1'b0, '0, 1'b0);
        end
        repeat (3) cycle(rnd(), 1'b0, '0, 1'b0);
        apply_reset(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
